// File: rtl/poker_types.sv
// poker_types: shared card/deck definitions for the card_deck block.
//   card_t       : 6-bit packed card {suit[1:0], rank[3:0]}
//   DECK_SIZE    : number of cards in a deck (52)
//   LFSR_SEED    : reset value of the shuffle LFSR
//   LFSR_TAPS    : Galois feedback mask for x^16+x^14+x^13+x^11+1
//   ordered_card : card at position idx of a freshly ordered deck
package poker_types;

  localparam int SUIT_W         = 2;
  localparam int RANK_W         = 4;
  localparam int CARD_W         = SUIT_W + RANK_W;
  localparam int DECK_SIZE      = 52;
  localparam int RANKS_PER_SUIT = 13;
  localparam int IDX_W          = 6;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DECK_SIZE - 1);
  localparam logic [15:0]      LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form: taps at bits 15, 13, 12, 10.
  localparam logic [15:0]      LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [SUIT_W-1:0] suit;
    logic [RANK_W-1:0] rank;
  } card_t;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_SHUFFLE = 1'b1
  } deck_state_e;

  function automatic card_t ordered_card(input int unsigned idx);
    card_t c;
    c.suit = SUIT_W'(idx / RANKS_PER_SUIT);
    c.rank = RANK_W'(idx % RANKS_PER_SUIT);
    return c;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1).
//   clk   : rising-edge clock; the register advances on every edge
//   reset : asynchronous active-low reset, loads LFSR_SEED
//   q     : current LFSR state (directly from the register)
module lfsr16
  import poker_types::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next LFSR value: shift right, fold the outgoing bit back through the taps.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_TAPS;
    end else begin
      lfsr_d = lfsr_d;
    end
  end

  // LFSR state register; the non-zero seed keeps it out of the all-zero lock-up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/card_deck.sv
// card_deck: 52-card deck with in-place Fisher-Yates shuffle and draw pointer.
//   clk           : rising-edge clock for all state
//   reset         : asynchronous active-low reset (ordered deck, IDLE)
//   start_shuffle : one-cycle request to shuffle (takes priority over draw)
//   draw_card     : one-cycle request to advance top_card_idx (saturates at 51)
//   ready         : high in IDLE, low for the 51 shuffle cycles
//   top_card      : deck[top_card_idx], combinational
module card_deck
  import poker_types::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  start_shuffle,
  input  logic  draw_card,
  output logic  ready,
  output card_t top_card
);

  deck_state_e      state_q;
  deck_state_e      state_d;
  logic [IDX_W-1:0] k_q;
  logic [IDX_W-1:0] k_d;
  logic [IDX_W-1:0] top_card_idx;
  logic [IDX_W-1:0] top_card_idx_d;
  card_t            deck   [DECK_SIZE];
  card_t            deck_d [DECK_SIZE];

  logic [15:0]      lfsr_val;
  logic [13:0]      prod_s;
  logic [IDX_W-1:0] j_s;
  logic [7:0]       prod_frac_unused;
  logic [7:0]       lfsr_hi_unused;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_val)
  );

  // j = (r * (k+1)) >> 8 with r in 0..255 scales r onto 0..k without a divider.
  assign prod_s           = {6'd0, lfsr_val[7:0]} * ({8'd0, k_q} + 14'd1);
  assign j_s              = prod_s[13:8];
  assign prod_frac_unused = prod_s[7:0];
  assign lfsr_hi_unused   = lfsr_val[15:8];

  assign ready    = (state_q == ST_IDLE);
  assign top_card = deck[top_card_idx];

  // Next-state logic for the IDLE/SHUFFLE controller, loop index and draw pointer.
  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    top_card_idx_d = top_card_idx;
    case (state_q)
      ST_IDLE: begin
        if (start_shuffle) begin
          state_d        = ST_SHUFFLE;
          k_d            = LAST_IDX;
          top_card_idx_d = 6'd0;
        end else if (draw_card && (top_card_idx < LAST_IDX)) begin
          top_card_idx_d = top_card_idx + 6'd1;
        end else begin
          top_card_idx_d = top_card_idx;
        end
      end
      ST_SHUFFLE: begin
        k_d = k_q - 6'd1;
        // k = 1 is the last swap; k = 0 would only swap a card with itself.
        if (k_q == 6'd1) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SHUFFLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        k_d     = LAST_IDX;
      end
    endcase
  end

  // Deck next value: hold, or swap deck[k] and deck[j] while shuffling.
  always_comb begin
    for (int i = 0; i < DECK_SIZE; i++) begin
      deck_d[i] = deck[i];
    end
    if (state_q == ST_SHUFFLE) begin
      // When j == k both writes carry the same card, so the deck is unchanged.
      deck_d[k_q] = deck[j_s];
      deck_d[j_s] = deck[k_q];
    end else begin
      deck_d[0] = deck[0];
    end
  end

  // Controller, loop index and draw pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      k_q          <= LAST_IDX;
      top_card_idx <= 6'd0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      top_card_idx <= top_card_idx_d;
    end
  end

  // Deck register array; reset restores the ordered deck.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DECK_SIZE; i++) begin
        deck[i] <= ordered_card(i);
      end
    end else begin
      for (int i = 0; i < DECK_SIZE; i++) begin
        deck[i] <= deck_d[i];
      end
    end
  end

endmodule

// File: tb/tb_card_deck.sv
// tb_card_deck: directed self-checking bench for card_deck.
module tb_card_deck;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_shuffle;
  logic       draw_card;
  logic       ready;
  logic [5:0] top_card;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_lfsr;
  logic [5:0]  m_deck [52];
  logic [5:0]  perm_a [52];

  card_deck dut (
    .clk           (clk),
    .reset         (reset),
    .start_shuffle (start_shuffle),
    .draw_card     (draw_card),
    .ready         (ready),
    .top_card      (top_card)
  );

  always #5 clk = ~clk;

  // Reference LFSR written bit by bit from x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    for (int b = 0; b < 15; b++) n[b] = s[b+1];
    n[15] = s[0];
    n[13] = s[14] ^ s[0];
    n[12] = s[13] ^ s[0];
    n[10] = s[11] ^ s[0];
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_step(m_lfsr);
  end

  function automatic logic [5:0] ord(input int i);
    logic [1:0] s;
    logic [3:0] r;
    s = 2'(i / 13);
    r = 4'(i % 13);
    return {s, r};
  endfunction

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_ordered();
    for (int i = 0; i < 52; i++) m_deck[i] = ord(i);
  endtask

  task automatic check_deck_model(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 52; i++) if (dut.deck[i] !== m_deck[i]) bad++;
    check_val(tag, 16'(bad), 16'd0);
  endtask

  task automatic check_distinct(input string tag);
    logic [51:0] seen;
    logic [5:0]  c;
    int          cnt;
    int          pos;
    seen = '0;
    cnt  = 0;
    for (int i = 0; i < 52; i++) begin
      c = dut.deck[i];
      if (c[3:0] < 4'd13) begin
        pos = int'(c[5:4]) * 13 + int'(c[3:0]);
        if (!seen[pos]) begin
          seen[pos] = 1'b1;
          cnt++;
        end
      end
    end
    check_val(tag, 16'(cnt), 16'd52);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_ready"}, 16'(ready), 16'd1);
    check_val({tag, "_idx"}, 16'(dut.top_card_idx), 16'd0);
    check_val({tag, "_top_card"}, 16'(top_card), 16'd0);
    check_deck_model({tag, "_deck_ordered"});
  endtask

  // Shuffle with model tracking; 'both' raises draw with start, 'poke' pulses inputs mid-shuffle.
  task automatic run_shuffle(input string tag, input bit both, input bit poke);
    int         kk;
    int         jj;
    int         low;
    logic [5:0] t;
    @(negedge clk);
    start_shuffle = 1'b1;
    draw_card     = both;
    @(negedge clk);
    start_shuffle = 1'b0;
    draw_card     = 1'b0;
    check_val({tag, "_ready_drop"}, 16'(ready), 16'd0);
    kk  = 51;
    low = 0;
    while (ready === 1'b0 && low < 60) begin
      if (kk >= 1) begin
        jj = (int'(m_lfsr[7:0]) * (kk + 1)) >> 8;
        t          = m_deck[kk];
        m_deck[kk] = m_deck[jj];
        m_deck[jj] = t;
        kk--;
      end
      if (poke) begin
        draw_card     = (low == 10);
        start_shuffle = (low == 20);
      end
      low++;
      @(negedge clk);
    end
    start_shuffle = 1'b0;
    draw_card     = 1'b0;
    check_val({tag, "_busy_cycles"}, 16'(low), 16'd51);
    check_val({tag, "_idx"}, 16'(dut.top_card_idx), 16'd0);
    check_deck_model({tag, "_deck_model"});
    check_distinct({tag, "_distinct"});
    check_val({tag, "_top_card"}, 16'(top_card), 16'(m_deck[0]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int diff;
    reset         = 1'b0;
    start_shuffle = 1'b0;
    draw_card     = 1'b0;
    model_ordered();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("por");

    // Draw through the whole ordered deck, then one extra draw at the end.
    for (int i = 0; i < 51; i++) begin
      check_val($sformatf("draw_idx_%0d", i), 16'(dut.top_card_idx), 16'(i));
      check_val($sformatf("draw_card_%0d", i), 16'(top_card), 16'(ord(i)));
      draw_card = 1'b1;
      @(negedge clk);
      draw_card = 1'b0;
    end
    check_val("draw_idx_51", 16'(dut.top_card_idx), 16'd51);
    check_val("draw_card_51", 16'(top_card), 16'(ord(51)));
    draw_card = 1'b1;
    @(negedge clk);
    draw_card = 1'b0;
    check_val("draw_saturate_idx", 16'(dut.top_card_idx), 16'd51);
    check_val("draw_saturate_ready", 16'(ready), 16'd1);

    run_shuffle("shuf1", 1'b0, 1'b0);

    // Draw a few cards from the shuffled deck.
    for (int i = 0; i < 4; i++) begin
      draw_card = 1'b1;
      @(negedge clk);
      draw_card = 1'b0;
    end
    check_val("shuf_draw_idx", 16'(dut.top_card_idx), 16'd4);
    check_val("shuf_draw_card", 16'(top_card), 16'(m_deck[4]));

    // Start and draw together, plus ignored inputs mid-shuffle; reshuffles the permuted deck.
    run_shuffle("shuf2", 1'b1, 1'b1);

    // Reset in the middle of a shuffle.
    @(negedge clk);
    start_shuffle = 1'b1;
    @(negedge clk);
    start_shuffle = 1'b0;
    repeat (20) @(negedge clk);
    check_val("mid_busy", 16'(ready), 16'd0);
    reset = 1'b0;
    model_ordered();
    #1;
    check_reset_state("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Two shuffles from the ordered deck with different idle gaps.
    repeat (3) @(negedge clk);
    run_shuffle("gapA", 1'b0, 1'b0);
    for (int i = 0; i < 52; i++) perm_a[i] = dut.deck[i];
    reset = 1'b0;
    model_ordered();
    @(negedge clk);
    reset = 1'b1;
    repeat (17) @(negedge clk);
    run_shuffle("gapB", 1'b0, 1'b0);
    diff = 0;
    for (int i = 0; i < 52; i++) if (dut.deck[i] !== perm_a[i]) diff++;
    check_val("gap_perm_differ", 16'(diff != 0), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
